// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-cycle data RAM.
// One op in flight: IDLE -> ACCESS -> RESP, with early RESP for misaligned or illegal ops.
module mem_access_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_ale,
    output logic        ram_en,
    output logic        ram_write_en,
    output logic        ram_read_en,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_select,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [1:0] SzB = 2'd0;
    localparam logic [1:0] SzH = 2'd1;
    localparam logic [1:0] SzW = 2'd2;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ale_q;

    function automatic logic op_legal(input logic [3:0] op);
        logic res;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b1010: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] res;
        case (op)
            4'b0000, 4'b0011, 4'b1000: res = SzB;
            4'b0001, 4'b0100, 4'b1001: res = SzH;
            default:                   res = SzW;
        endcase
        return res;
    endfunction

    logic [1:0]  req_size;
    logic        req_legal;
    logic        req_misaligned;
    logic [31:0] req_addr_eff;

    always_comb begin
        req_size       = op_size(req_op);
        req_legal      = op_legal(req_op);
        req_misaligned = CHECK_ALIGN && req_legal &&
                         (((req_size == SzH) && req_addr[0]) ||
                          ((req_size == SzW) && (req_addr[1:0] != 2'b00)));
        // Without alignment checking, sub-word alignment of H/W ops is simply dropped.
        req_addr_eff   = (!CHECK_ALIGN && (req_size != SzB)) ? {req_addr[31:2], 2'b00}
                                                              : req_addr;
    end

    assign req_ready = (state_q == StIdle) && !flush && !rst;

    logic        is_access;
    logic        is_store;
    logic [1:0]  size_q;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] load_data;

    always_comb begin
        is_access = (state_q == StAccess);
        is_store  = op_q[3];
        size_q    = op_size(op_q);

        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
        if (size_q == SzB) begin
            lane_mask  = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
        end else if (size_q == SzH) begin
            lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_q[15:0]}};
        end

        shifted = ram_rdata >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (op_q)
            4'b0000: load_data = {{24{shifted[7]}}, shifted[7:0]};
            4'b0011: load_data = {24'h0, shifted[7:0]};
            4'b0001: load_data = {{16{half[15]}}, half};
            4'b0100: load_data = {16'h0, half};
            4'b0010: load_data = ram_rdata;
            default: load_data = 32'h0;
        endcase

        ram_en       = is_access;
        ram_write_en = is_access && is_store;
        ram_read_en  = is_access && !is_store;
        ram_addr     = is_access ? addr_q : 32'h0;
        ram_select   = is_access ? lane_mask : 4'h0;
        ram_wdata    = (is_access && is_store) ? lane_wdata : 32'h0;
    end

    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_ale   = ale_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ale_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr_eff;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'h0;
                        if (!req_legal) begin
                            ale_q   <= 1'b0;
                            state_q <= StResp;
                        end else if (req_misaligned) begin
                            ale_q   <= 1'b1;
                            state_q <= StResp;
                        end else begin
                            ale_q   <= 1'b0;
                            state_q <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    // RAM strobes already issued this cycle; flush only drops the result.
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        rdata_q <= load_data;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (flush || resp_ready) begin
                        rdata_q <= 32'h0;
                        ale_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 4 KiB byte-lane RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_ale;
    logic        ram_en;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_select;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_access_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_ale     (resp_ale),
        .ram_en       (ram_en),
        .ram_write_en (ram_write_en),
        .ram_read_en  (ram_read_en),
        .ram_addr     (ram_addr),
        .ram_select   (ram_select),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[11:2]];

    always @(posedge clk) begin
        if (ram_en && ram_write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_select[k]) mem[ram_addr[11:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
            end
        end
    end

    // Present one op; returns #1 after the accepting edge (first cycle after accept).
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        next_cycle();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++;
            $display("FAIL rst_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_rvalid got=%b exp=0", resp_valid); end
        checks++; if (ram_en !== 1'b0) begin errors++;
            $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word();
        issue(4'b1010, 32'h100, 32'h11223344);
        checks++; if ({ram_en, ram_write_en, ram_read_en} !== 3'b110) begin errors++;
            $display("FAIL stw_strobes got=%b exp=110", {ram_en, ram_write_en, ram_read_en}); end
        checks++; if (ram_select !== 4'b1111) begin errors++;
            $display("FAIL stw_sel got=%b exp=1111", ram_select); end
        checks++; if (ram_addr !== 32'h100 || ram_wdata !== 32'h11223344) begin errors++;
            $display("FAIL stw_bus got=%h/%h exp=100/11223344", ram_addr, ram_wdata); end
        next_cycle();
        checks++; if ({resp_valid, resp_ale} !== 2'b10 || resp_rdata !== 32'h0) begin errors++;
            $display("FAIL stw_resp got=%b%b/%h exp=10/0", resp_valid, resp_ale, resp_rdata); end
        consume();
        issue(4'b0010, 32'h100, 32'h0);
        checks++; if ({ram_en, ram_write_en, ram_read_en, ram_select} !== 7'b1011111) begin
            errors++;
            $display("FAIL ldw_strobes got=%b exp=1011111",
                     {ram_en, ram_write_en, ram_read_en, ram_select}); end
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344 || resp_ale !== 1'b0)
            begin errors++;
            $display("FAIL ldw_resp got=%b/%h/%b exp=1/11223344/0",
                     resp_valid, resp_rdata, resp_ale); end
        consume();
    endtask

    task automatic test_byte();
        issue(4'b1000, 32'h103, 32'h000000A5);
        checks++; if (ram_select !== 4'b1000 || ram_wdata !== 32'hA5A5A5A5) begin errors++;
            $display("FAIL stb_lane got=%b/%h exp=1000/a5a5a5a5", ram_select, ram_wdata); end
        next_cycle();
        consume();
        issue(4'b0000, 32'h103, 32'h0);
        checks++; if (ram_select !== 4'b1000) begin errors++;
            $display("FAIL ldb_sel got=%b exp=1000", ram_select); end
        next_cycle();
        checks++; if (resp_rdata !== 32'hFFFFFFA5) begin errors++;
            $display("FAIL ldb_sext got=%h exp=ffffffa5", resp_rdata); end
        consume();
        issue(4'b0011, 32'h103, 32'h0);
        next_cycle();
        checks++; if (resp_rdata !== 32'h000000A5) begin errors++;
            $display("FAIL ldbu_zext got=%h exp=000000a5", resp_rdata); end
        consume();
    endtask

    task automatic test_half();
        issue(4'b0001, 32'h101, 32'h0);
        checks++; if (ram_en !== 1'b0) begin errors++;
            $display("FAIL ldh_mis_ram_en got=%b exp=0", ram_en); end
        checks++; if ({resp_valid, resp_ale} !== 2'b11 || resp_rdata !== 32'h0) begin errors++;
            $display("FAIL ldh_mis_resp got=%b%b/%h exp=11/0", resp_valid, resp_ale, resp_rdata); end
        consume();
        checks++; if (ram_en !== 1'b0 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL ldh_mis_after got=%b%b exp=00", ram_en, resp_valid); end
        issue(4'b1001, 32'h102, 32'h00008001);
        checks++; if (ram_select !== 4'b1100 || ram_wdata !== 32'h80018001) begin errors++;
            $display("FAIL sth_lane got=%b/%h exp=1100/80018001", ram_select, ram_wdata); end
        next_cycle();
        consume();
        issue(4'b0100, 32'h102, 32'h0);
        next_cycle();
        checks++; if (resp_rdata !== 32'h00008001) begin errors++;
            $display("FAIL ldhu got=%h exp=00008001", resp_rdata); end
        consume();
        issue(4'b0001, 32'h102, 32'h0);
        next_cycle();
        checks++; if (resp_rdata !== 32'hFFFF8001) begin errors++;
            $display("FAIL ldh_sext got=%h exp=ffff8001", resp_rdata); end
        consume();
        issue(4'b0010, 32'h100, 32'h0);
        next_cycle();
        checks++; if (resp_rdata !== 32'h80013344) begin errors++;
            $display("FAIL ldw_merged got=%h exp=80013344", resp_rdata); end
        consume();
    endtask

    task automatic test_illegal();
        issue(4'b0101, 32'h100, 32'h0);
        checks++; if ({ram_en, resp_valid, resp_ale} !== 3'b010 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal got=%b%b%b/%h exp=010/0",
                     ram_en, resp_valid, resp_ale, resp_rdata); end
        consume();
    endtask

    task automatic test_backpressure();
        issue(4'b0010, 32'h100, 32'h0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h80013344 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got=%b/%h/%b exp=1/80013344/0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            next_cycle();
        end
        consume();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL hold_release got=%b%b exp=01", resp_valid, req_ready); end
    endtask

    task automatic test_flush();
        issue(4'b1010, 32'h200, 32'hCAFEF00D);
        flush = 1'b1;
        #1;
        checks++; if (ram_write_en !== 1'b1 || ram_addr !== 32'h200) begin errors++;
            $display("FAIL flush_acc_write got=%b/%h exp=1/200", ram_write_en, ram_addr); end
        next_cycle();
        flush = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL flush_acc_drop got=%b%b exp=01", resp_valid, req_ready); end
        issue(4'b0010, 32'h200, 32'h0);
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL flush_committed got=%b/%h exp=1/cafef00d", resp_valid, resp_rdata); end
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL flush_resp got=%b%b exp=01", resp_valid, req_ready); end
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_addr  = 32'h200;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++;
            $display("FAIL flush_idle_ready got=%b exp=0", req_ready); end
        next_cycle();
        checks++; if (ram_en !== 1'b0 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL flush_idle_noaccept got=%b%b exp=00", ram_en, resp_valid); end
        flush     = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(4'b1010, 32'h300, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        checks++; if ({ram_en, ram_write_en, ram_select, req_ready, resp_valid} !== 8'h00 ||
                      ram_wdata !== 32'h0 || ram_addr !== 32'h0) begin errors++;
            $display("FAIL rst_mid_outputs got=%b%b%b%b%b/%h/%h exp=0",
                     ram_en, ram_write_en, ram_select, req_ready, resp_valid,
                     ram_wdata, ram_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        issue(4'b0010, 32'h300, 32'h0);
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_mid_nocommit got=%b/%h exp=1/0", resp_valid, resp_rdata); end
        consume();
        issue(4'b0010, 32'h200, 32'h0);
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL rst_mid_new_op got=%b/%h exp=1/cafef00d", resp_valid, resp_rdata); end
        consume();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter CHECK_ALIGN, default 1: when 1, misaligned halfword/word accesses raise resp_ale; when 0, addr[1:0] is forced to 0 for them.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a memory op.
REQ-005 req_ready  output  1  unit can accept an op.
REQ-006 req_op  input  4  op: 0000 LD_B, 0001 LD_H, 0010 LD_W, 0011 LD_BU, 0100 LD_HU, 1000 ST_B, 1001 ST_H, 1010 ST_W; other codes are illegal.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 flush  input  1  synchronous pipeline flush.
REQ-010 resp_valid  output  1  completion available.
REQ-011 resp_ready  input  1  pipeline consumes completion.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores, illegal ops and exceptions.
REQ-013 resp_ale  output  1  address-misaligned exception flag for this completion.
REQ-014 ram_en, ram_write_en, ram_read_en  output  1 each  data RAM strobes.
REQ-015 ram_addr  output  32  RAM byte address (RAM uses bits 11:2).
REQ-016 ram_select  output  4  byte-lane enables, bit k = bits 8k+7:8k.
REQ-017 ram_wdata  output  32  lane-positioned store data.
REQ-018 ram_rdata  input  32  combinational RAM read data.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE with flush = 0.
REQ-020 IDLE: on req_valid & req_ready, latch op/addr/wdata; go to ACCESS, or straight to RESP with resp_ale = 1 if misaligned, or straight to RESP with resp_ale = 0 if illegal op.
REQ-021 Misaligned: H ops with addr[0] = 1; W ops with addr[1:0] != 0 (only when CHECK_ALIGN = 1). A misaligned access never asserts ram_en.
REQ-022 ACCESS lasts exactly one cycle: ram_en = 1; ram_read_en = 1 for loads; ram_write_en = 1 for stores; ram_addr = latched addr; at the rising edge ending ACCESS, the extracted load data is registered and the FSM moves to RESP.
REQ-023 ram_select: B = 1 << addr[1:0]; H = 0011 when addr[1] = 0, else 1100; W = 1111; for loads, ram_select equals the same lane mask.
REQ-024 ram_wdata: B replicates byte on all four lanes; H replicates halfword on both halves; W passes through.
REQ-025 Load extract: select the byte/halfword at addr[1:0]; LD_B/LD_H sign-extend; LD_BU/LD_HU zero-extend; LD_W passes through.
REQ-026 Outside ACCESS, all ram_* outputs are 0.
REQ-027 RESP: resp_valid = 1; resp_rdata/resp_ale are held stable until resp_ready = 1, then go to IDLE. resp_valid is low in all other states.
REQ-028 Latency: accept at edge N, ACCESS in cycle N+1, resp_valid from cycle N+2; misaligned/illegal ops give resp_valid from cycle N+1.
REQ-029 Peak throughput: one op per 3 cycles.
REQ-030 Flush in IDLE: no accept that cycle.
REQ-031 Flush in ACCESS: the RAM strobes still issue that cycle, so a store commits; the result is discarded and the FSM goes to IDLE.
REQ-032 Flush in RESP: the response is dropped and the FSM goes to IDLE; flush has priority over resp_ready.

Reset
REQ-033 rst asserted at any time (including mid-ACCESS): state = IDLE and all outputs read 0 immediately (req_ready becomes 1 once rst deasserts), and the latched op/addr/wdata/rdata registers clear to 0.
REQ-034 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-035 ST_W addr 0x100, wdata 0x11223344, then LD_W 0x100: ACCESS shows select 1111 and write_en 1; the load gives resp_rdata 0x11223344 and resp_ale 0 at cycle N+2.
REQ-036 ST_B addr 0x103, wdata 0x000000A5: select 1000, ram_wdata 0xA5A5A5A5. Then LD_B 0x103 gives 0xFFFFFFA5 and LD_BU 0x103 gives 0x000000A5.
REQ-037 LD_H at addr 0x101: no ram_en in any cycle; resp_valid at N+1 with resp_ale 1 and resp_rdata 0. LD_HU 0x102 with word 0x8001xxxx gives 0x00008001.
REQ-038 resp_ready held 0 for 5 cycles in RESP: resp_valid and data remain stable and req_ready stays 0; releasing resp_ready returns the FSM to IDLE on the next edge.
REQ-039 flush during ACCESS of ST_W 0x200: the RAM write still occurs and no resp_valid follows. flush during RESP: resp_valid drops the next cycle.
REQ-040 rst pulsed during ACCESS of a store: all outputs 0 asynchronously; after release, req_ready = 1 and a new op completes normally.
